// File: rtl/aes_pkg.sv
// Shared AES types, constants and key-schedule helpers.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        EMIT   = 2'd2
    } state_t;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] key_t;

    // Round constants, index 1..10 (AES-128).
    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        int idx;
        idx = 2040 - 8 * int'(b);
        return SBOX_TABLE[idx +: 8];
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rcon placed in the top byte; rounds outside 1..10 contribute nothing.
    function automatic word_t rcon_word(input logic [3:0] rnd);
        word_t r;
        r = '0;
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            r = {RCON[rnd], 24'h0};
        end
        return r;
    endfunction

    // One forward step; t = SubWord(RotWord(w3)) ^ Rcon.
    function automatic key_t key_fwd(input key_t k, input word_t t);
        word_t w0, w1, w2, w3;
        w0 = k[127:96] ^ t;
        w1 = k[95:64]  ^ w0;
        w2 = k[63:32]  ^ w1;
        w3 = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // One inverse step; t = SubWord(RotWord(w3 ^ w2)) ^ Rcon of the current round.
    function automatic key_t key_inv(input key_t k, input word_t t);
        word_t w0p, w1p, w2p, w3p;
        w3p = k[31:0]   ^ k[63:32];
        w2p = k[63:32]  ^ k[95:64];
        w1p = k[95:64]  ^ k[127:96];
        w0p = k[127:96] ^ t;
        return {w0p, w1p, w2p, w3p};
    endfunction

endpackage

// File: rtl/aes_dec_key_sched_if.sv
// Handshake bundle between the decryption key scheduler and its user.
// Handshake: a key transfers on a rising clk edge where out_valid && out_ready;
// while out_valid is high and out_ready low, key_out/round_out hold stable.
interface aes_dec_key_sched_if;
    import aes_pkg::*;

    logic       start;
    key_t       key_in;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    key_t       key_out;
    logic [3:0] round_out;
    logic       done;
    state_t     state_dbg;

    modport master (
        output start, key_in, out_ready,
        input  busy, out_valid, key_out, round_out, done, state_dbg
    );

    modport slave (
        input  start, key_in, out_ready,
        output busy, out_valid, key_out, round_out, done, state_dbg
    );
endinterface

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four forward S-box lookups on a 32-bit word.
module aes_sbox_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);
    // One lookup per byte lane.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign word_o[8*i +: 8] = sbox_byte(word_i[8*i +: 8]);
    end
endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption key scheduler: expands forward to the round-10 key,
// then steps backwards emitting round keys 10..0 on a valid/ready port.
// Only one 128-bit working key is held; the S-box word is shared by both steps.
module aes_dec_key_sched
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_dec_key_sched_if.slave   bus
);
    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t     state_q, state_d;
    key_t       key_q, key_d;
    logic [3:0] rnd_q, rnd_d;
    logic       done_q, done_d;

    word_t      sub_in;
    word_t      sub_out;
    word_t      step_word;

    // Pick the word fed to the shared S-box: w3 going forward, w3^w2 going back.
    always_comb begin
        sub_in = rot_word(key_q[31:0]);
        if (state_q == EMIT) begin
            sub_in = rot_word(key_q[31:0] ^ key_q[63:32]);
        end
    end

    aes_sbox_word u_sbox (
        .word_i (sub_in),
        .word_o (sub_out)
    );

    assign step_word = sub_out ^ rcon_word(rnd_q);

    // Next-state and working-key update.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (bus.start && !done_q) begin
                    key_d   = bus.key_in;
                    rnd_d   = 4'd1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                key_d = key_fwd(key_q, step_word);
                if (rnd_q == LAST_RND) begin
                    state_d = EMIT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (rnd_q != 4'd0) begin
                        key_d = key_inv(key_q, step_word);
                        rnd_d = rnd_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working key, round counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            rnd_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == EMIT);
    assign bus.key_out   = key_q;
    assign bus.round_out = rnd_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Directed bench for the AES-128 decryption key scheduler.
module tb_aes_dec_key_sched;
    import aes_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_dec_key_sched_if bus();

    aes_dec_key_sched #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Entry: {key_known, round[3:0], key[127:0]}
    logic [132:0] exp_q[$];

    key_t fips_rk [0:10];
    key_t fips_key;

    bit         done_exp   = 1'b0;
    bit         stall_prev = 1'b0;
    key_t       key_prev;
    logic [3:0] rnd_prev;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            done_exp   = 1'b0;
        end else begin
            if (done_exp || bus.done === 1'b1) begin
                check("done_pulse", 128'(bus.done), 128'(done_exp));
            end
            done_exp = 1'b0;
            if (stall_prev) begin
                check("stall_valid", 128'(bus.out_valid), 128'd1);
                check("stall_key", bus.key_out, key_prev);
                check("stall_round", 128'(bus.round_out), 128'(rnd_prev));
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            key_prev   = bus.key_out;
            rnd_prev   = bus.round_out;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_key: got round %0d key %h want none", bus.round_out, bus.key_out);
                end else begin
                    logic [132:0] e;
                    e = exp_q.pop_front();
                    check("round_out", 128'(bus.round_out), 128'(e[131:128]));
                    if (e[132]) check("key_out", bus.key_out, e[127:0]);
                    if (bus.round_out == 4'd0) done_exp = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_fips();
        for (int r = 10; r >= 0; r--) exp_q.push_back({1'b1, 4'(r), fips_rk[r]});
    endtask

    task automatic push_zero();
        for (int r = 10; r >= 0; r--) begin
            case (r)
                10: exp_q.push_back({1'b1, 4'(r), 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
                2:  exp_q.push_back({1'b1, 4'(r), 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa});
                1:  exp_q.push_back({1'b1, 4'(r), 128'h62636363626363636263636362636363});
                0:  exp_q.push_back({1'b1, 4'(r), 128'h0});
                default: exp_q.push_back({1'b0, 4'(r), 128'h0});
            endcase
        end
    endtask

    function automatic logic next_ready(input int mode);
        return (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    // mode 0: out_ready always high; mode 1: random backpressure.
    // inject: pulse start with another key during EXPAND and EMIT.
    // drop_start: assert start in the done cycle and confirm it is ignored.
    task automatic run_seq(input key_t k, input int mode, input bit inject, input bit drop_start);
        int cnt;
        int n;
        @(posedge clk); #1;
        bus.key_in    = k;
        bus.start     = 1'b1;
        bus.out_ready = next_ready(mode);
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.key_in = ~k;
        check("busy_expand", 128'(bus.busy), 128'd1);
        cnt = 1;
        while (!bus.out_valid && cnt < 40) begin
            if (inject && cnt == 5) begin
                bus.start  = 1'b1;
                bus.key_in = 128'h0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
            bus.out_ready = next_ready(mode);
        end
        bus.start = 1'b0;
        check("latency", 128'(cnt), 128'd11);
        n = 0;
        while (!bus.done && n < 300) begin
            if (inject && n == 3) begin
                bus.start  = 1'b1;
                bus.key_in = 128'h0;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            bus.out_ready = next_ready(mode);
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done within 300 cycles");
        end
        if (drop_start) begin
            bus.start  = 1'b1;
            bus.key_in = k;
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("dropped_start_busy", 128'(bus.busy), 128'd0);
            check("dropped_start_valid", 128'(bus.out_valid), 128'd0);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic reset_mid_emit();
        int n;
        push_fips();
        @(posedge clk); #1;
        bus.key_in    = fips_key;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!(bus.out_valid && bus.round_out == 4'd5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_round5", 128'(bus.round_out), 128'd5);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_mid_valid", 128'(bus.out_valid), 128'd0);
        check("rst_mid_busy", 128'(bus.busy), 128'd0);
        check("rst_mid_done", 128'(bus.done), 128'd0);
        check("rst_mid_round", 128'(bus.round_out), 128'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_done", 128'(bus.done), 128'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        fips_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[0]  = fips_key;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.key_in    = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_valid", 128'(bus.out_valid), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_key", bus.key_out, 128'h0);
        check("rst_round", 128'(bus.round_out), 128'd0);
        check("rst_state", 128'(bus.state_dbg), 128'(IDLE));
        rst = 1'b0;

        // Nominal, then back-to-back start in the cycle after done.
        push_fips();
        run_seq(fips_key, 0, 1'b0, 1'b0);
        push_fips();
        run_seq(fips_key, 0, 1'b0, 1'b0);

        // Backpressure.
        push_fips();
        run_seq(fips_key, 1, 1'b0, 1'b0);

        // Zero key, with a start in the done cycle that must be dropped.
        push_zero();
        run_seq(128'h0, 0, 1'b0, 1'b1);

        // Start pulses while busy must not disturb the sequence.
        push_fips();
        run_seq(fips_key, 0, 1'b1, 1'b0);

        // Reset mid-emit, then a fresh full sequence.
        reset_mid_emit();
        push_fips();
        run_seq(fips_key, 1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
